// File: rtl/addsub_result_decoder.sv
// Converts one add/sub datapath result to sign + BCD magnitude (shift-add-3).
// Optional ADDSUB_DEC_ERRCHK_EN adds a sticky o_err for starts while busy.
module addsub_result_decoder #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_mode,
    input  logic [WIDTH-1:0]      i_sum,
    input  logic                  i_carry,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sign,
`ifdef ADDSUB_DEC_ERRCHK_EN
    output logic                  o_err,
`endif
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int MW = WIDTH + 1;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(MW + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic            mode_q, carry_q, sign_q;
    logic [WIDTH-1:0] sum_q;
    logic [MW-1:0]   mag_q;
    logic [BW-1:0]   bcd_q;
    logic [CW-1:0]   cnt_q;

    logic [WIDTH-1:0] neg;
    logic [MW-1:0]   mag_load, mag_shift;
    logic            sign_load;
    logic [BW-1:0]   adj, bcd_shift;
    logic            last;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = (state_q == DONE);
    assign last   = (cnt_q == CW'(WIDTH));

    // Borrow (carry=0) in subtract mode means a<b: magnitude is the two's complement.
    always_comb begin
        neg       = ~sum_q + WIDTH'(1);
        mag_load  = {carry_q, sum_q};
        sign_load = 1'b0;
        if (mode_q) begin
            if (carry_q) begin
                mag_load = {1'b0, sum_q};
            end else begin
                sign_load = 1'b1;
                mag_load  = (neg == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, neg};
            end
        end
    end

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bcd_shift = {adj[BW-2:0], mag_q[MW-1]};
        mag_shift = {mag_q[MW-2:0], 1'b0};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            o_sign  <= 1'b0;
            o_bcd   <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    mode_q  <= i_mode;
                    sum_q   <= i_sum;
                    carry_q <= i_carry;
                end
                LOAD: begin
                    mag_q  <= mag_load;
                    sign_q <= sign_load;
                    bcd_q  <= '0;
                    cnt_q  <= '0;
                end
                SHIFT: begin
                    bcd_q <= bcd_shift;
                    mag_q <= mag_shift;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        o_bcd  <= bcd_shift;
                        o_sign <= sign_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDSUB_DEC_ERRCHK_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                          o_err <= 1'b0;
        else if (state_q == IDLE && i_start)  o_err <= 1'b0;
        else if (i_start && o_busy)           o_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_addsub_result_decoder.sv
// Self-checking bench for addsub_result_decoder (WIDTH=4, DIGITS=2).
module tb_addsub_result_decoder;

    logic       i_clk = 1'b0;
    logic       i_reset, i_start, i_mode, i_carry;
    logic [3:0] i_sum;
    logic       o_busy, o_done, o_sign;
    logic [7:0] o_bcd;
`ifdef ADDSUB_DEC_ERRCHK_EN
    logic       o_err;
`endif

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] prev_bcd = 8'h00;
    logic       prev_sign = 1'b0;

    addsub_result_decoder #(.WIDTH(4), .DIGITS(2)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_mode  (i_mode),
        .i_sum   (i_sum),
        .i_carry (i_carry),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_sign  (o_sign),
`ifdef ADDSUB_DEC_ERRCHK_EN
        .o_err   (o_err),
`endif
        .o_bcd   (o_bcd)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed integer value of the add/sub result, then decimal digits.
    function automatic void model(input logic m, input logic [3:0] s, input logic c,
                                  output logic [7:0] b, output logic sg);
        int v;
        if (!m) begin
            v  = (c ? 16 : 0) + int'(s);
            sg = 1'b0;
        end else if (c) begin
            v  = int'(s);
            sg = 1'b0;
        end else begin
            v  = 16 - int'(s);
            sg = 1'b1;
        end
        b = 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic conv(input logic m, input logic [3:0] s, input logic c,
                        input int glitch, input int abort);
        logic [7:0] eb;
        logic       es;
        model(m, s, c, eb, es);
        i_mode  = m;
        i_sum   = s;
        i_carry = c;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_sum   = 4'($urandom);
        i_mode  = 1'($urandom);
        i_carry = 1'($urandom);
        chk("busy_e0", o_busy, 1);
        chk("done_e0", o_done, 0);
`ifdef ADDSUB_DEC_ERRCHK_EN
        chk("err_clear", o_err, 0);
`endif
        for (int k = 1; k <= 7; k++) begin
            if (k == glitch) begin
                i_start = 1'b1;
                i_sum   = 4'($urandom);
                i_mode  = 1'($urandom);
                i_carry = 1'($urandom);
            end
            if (k == abort) i_reset = 1'b1;
            @(posedge i_clk); #1;
            i_start = 1'b0;
            if (k == abort) begin
                chk("rst_busy", o_busy, 0);
                chk("rst_done", o_done, 0);
                chk("rst_bcd", o_bcd, 0);
                chk("rst_sign", o_sign, 0);
`ifdef ADDSUB_DEC_ERRCHK_EN
                chk("rst_err", o_err, 0);
`endif
                i_reset = 1'b0;
                prev_bcd  = 8'h00;
                prev_sign = 1'b0;
                for (int j = 0; j < 9; j++) begin
                    @(posedge i_clk); #1;
                    chk("abort_nodone", o_done, 0);
                    chk("abort_idle", o_busy, 0);
                end
                return;
            end
            chk("done_tim", o_done, (k == 6) ? 1 : 0);
            chk("busy_tim", o_busy, (k <= 6) ? 1 : 0);
            chk("bcd", o_bcd, (k >= 6) ? eb : prev_bcd);
            chk("sign", o_sign, (k >= 6) ? es : prev_sign);
`ifdef ADDSUB_DEC_ERRCHK_EN
            if (glitch > 0 && k >= glitch) chk("err_set", o_err, 1);
`endif
        end
        prev_bcd  = eb;
        prev_sign = es;
    endtask

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_mode  = 1'b0;
        i_sum   = 4'h0;
        i_carry = 1'b0;
        #12;
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_done, 0);
        chk("reset_bcd", o_bcd, 0);
        chk("reset_sign", o_sign, 0);
`ifdef ADDSUB_DEC_ERRCHK_EN
        chk("reset_err", o_err, 0);
`endif
        @(negedge i_clk);
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        conv(1'b0, 4'hB, 1'b1, 0, 0);
        conv(1'b1, 4'h6, 1'b1, 0, 0);
        conv(1'b1, 4'hA, 1'b0, 0, 0);
        conv(1'b1, 4'h1, 1'b0, 0, 0);
        conv(1'b1, 4'h0, 1'b1, 0, 0);
        conv(1'b0, 4'hF, 1'b1, 0, 0);
        conv(1'b1, 4'h0, 1'b0, 0, 0);
        conv(1'b0, 4'h9, 1'b0, 2, 0);
        repeat (3) begin
            @(posedge i_clk); #1;
`ifdef ADDSUB_DEC_ERRCHK_EN
            chk("err_sticky", o_err, 1);
`endif
            chk("hold_bcd", o_bcd, prev_bcd);
        end
        conv(1'b0, 4'h3, 1'b1, 0, 0);
        conv(1'b1, 4'h7, 1'b0, 0, 3);
        for (int r = 0; r < 20; r++) begin
            conv(1'($urandom), 4'($urandom), 1'($urandom), 0, 0);
        end
        conv(1'b0, 4'h5, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
